rs_dec_sched_16_8: RTL and testbench
====================================

# rs_dec_sched_16_8

Stage scheduler for the RS(16,8) GF(256) t=4 decoder. It sequences the four decoder stages (syndrome, key-equation solver, Chien search, correction/output) as a 4-slot in-order pipeline, so up to four frames can be in flight. It issues stage start pulses and tracks done pulses. It routes frames around stages that are not needed (zero syndrome, KES failure) and emits one status record per frame in arrival order.

## Interface
- TAG_W, 2: frame-buffer slot tag width.
- TIMEOUT, 64: per-stage watchdog limit in cycles (≥2).
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid / in_ready  in/out  1  frame request handshake; `in_ready` = S slot IDLE (combinational from registered state).
- in_tag  in  TAG_W  buffer tag of the requested frame.
- syn_start  out  1;  syn_tag  out  TAG_W;  syn_done, syn_zero  in  1 (`syn_zero` = all 8 syndromes zero, valid with `syn_done`).
- kes_start  out  1;  kes_tag  out  TAG_W;  kes_done, kes_fail  in  1;  kes_deg  in  3 (λ degree, valid with `kes_done`).
- chien_start  out  1;  chien_tag  out  TAG_W;  chien_done  in  1;  chien_cnt  in  3 (roots found).
- cor_start, cor_bypass  out  1;  cor_tag  out  TAG_W;  cor_done  in  1.
- out_valid  out  1;  out_tag  out  TAG_W;  out_status  out  2 (00 clean, 01 corrected, 10 uncorrectable, 11 timeout);  out_nerr  out  3.
- busy  out  1  any slot not IDLE.

## Operation
- Four slots: S (syndrome), K (KES), C (Chien), R (correction). Each slot has state IDLE/RUN/DONE and holds tag, status, nerr, deg, plus a watchdog counter of width clog2(TIMEOUT+1).
- Accept: in_valid & in_ready → S becomes RUN with in_tag, status=00. in_valid is ignored while rst is asserted.
- RUN → DONE on the slot's done input, which is sampled only in RUN. A done in IDLE/DONE is ignored.
- Watchdog: it counts each RUN cycle. When it reaches TIMEOUT without a done, the slot goes to DONE with status=11. A done in the same cycle wins.
- Latched on done:
  - S: syn_zero.
  - K: kes_fail, deg=kes_deg.
  - C: uncorrectable if chien_cnt≠deg, else corrected with nerr=chien_cnt.
- Routing from DONE (decided on registered state; destination must be IDLE or vacating this cycle is NOT allowed; only IDLE counts):
  - S DONE, syn_zero=0, status 00 → K.
  - S DONE, syn_zero=1 or status 11 → R with bypass, but only if K and C are IDLE (preserves order).
  - K DONE, ok → C.
  - K DONE, kes_fail → R with status 10 and bypass, only if C is IDLE.
  - K DONE, timeout → R with status 11 and bypass, only if C is IDLE.
  - C DONE → R; bypass=1 unless status 01.
- R target priority when several request in one cycle: C > K > S.
- The source slot goes to IDLE in the transfer cycle. The destination goes to RUN at the next edge.
- start pulses: registered, one cycle, asserted in the first RUN cycle of the slot. The `*_tag` outputs hold the slot tag throughout RUN. cor_bypass is valid with cor_start and held.
- R DONE → out_valid pulses for one cycle with tag/status/nerr, then R goes IDLE. An R timeout reports status 11.
- nerr=0 for every status except 01.

## Timing
- Reset values: all slots IDLE, counters 0, all start/out_valid 0, tags/status/nerr 0, busy 0, in_ready 1.
- Accept at edge t → syn_start high in cycle t+1.
- Done sampled at edge d → slot DONE in d+1. Transfer at edge d+1 if the destination is IDLE → next start in cycle d+2. Scheduler overhead is 2 cycles per stage boundary.
- cor_done at edge e → out_valid in cycle e+1.
- Blocked DONE slots hold indefinitely; their watchdog is stopped. in_ready stays 0 while S is RUN/DONE.
- Reset mid-operation: all slots are dropped immediately and no out_valid is produced for in-flight frames.

## Test plan
- Single frame, tag 2, syn_zero=0, kes_deg=3, chien_cnt=3 → kes_start, chien_start, cor_start (bypass 0) in order, then out_valid with tag 2, status 01, nerr 3.
- Frame with syn_zero=1 on an empty pipe → no kes_start/chien_start; cor_start with bypass 1; out status 00, nerr 0.
- Frames A (errors) and B (syn_zero) back-to-back → B waits in S DONE until A leaves C. Output order is A then B.
- kes_fail=1 → chien is skipped, status 10. Separately, kes_deg=2 with chien_cnt=1 → status 10, nerr 0.
- chien_done withheld for TIMEOUT=64 cycles → frame forwarded with status 11 and bypass 1. A chien_done arriving in the 64th cycle instead gives a normal result.
- Four frames filling S/K/C/R with rst asserted mid-flight → all outputs zero next cycle, busy 0, in_ready 1, no out_valid.

Source files
------------

// File: rtl/rs_dec_sched_16_8.sv
// Stage scheduler for the RS(16,8) t=4 decoder.
// Four in-order slots (S: syndrome, K: key equation, C: Chien, R: correction)
// each hold one frame. Frames move forward only into an IDLE slot, skip
// stages they do not need, and leave R in arrival order with a status record.
module rs_dec_sched_16_8 #(
  parameter int TAG_W   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  output logic             syn_start,
  output logic [TAG_W-1:0] syn_tag,
  input  logic             syn_done,
  input  logic             syn_zero,
  output logic             kes_start,
  output logic [TAG_W-1:0] kes_tag,
  input  logic             kes_done,
  input  logic             kes_fail,
  input  logic [2:0]       kes_deg,
  output logic             chien_start,
  output logic [TAG_W-1:0] chien_tag,
  input  logic             chien_done,
  input  logic [2:0]       chien_cnt,
  output logic             cor_start,
  output logic             cor_bypass,
  output logic [TAG_W-1:0] cor_tag,
  input  logic             cor_done,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_status,
  output logic [2:0]       out_nerr,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} slot_st_t;

  localparam logic [1:0] ST_CLEAN = 2'b00;
  localparam logic [1:0] ST_CORR  = 2'b01;
  localparam logic [1:0] ST_UNCOR = 2'b10;
  localparam logic [1:0] ST_TMO   = 2'b11;

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  // Value of the counter during the TIMEOUT-th RUN cycle.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  slot_st_t         r_s_st, r_k_st, r_c_st, r_r_st;
  logic [TAG_W-1:0] r_s_tag, r_k_tag, r_c_tag, r_r_tag;
  logic [1:0]       r_s_status, r_k_status, r_c_status, r_r_status;
  logic [WD_W-1:0]  r_s_wd, r_k_wd, r_c_wd, r_r_wd;
  logic             r_s_zero;
  logic [2:0]       r_k_deg, r_c_deg;
  logic [2:0]       r_c_nerr, r_r_nerr;
  logic             r_r_bypass;
  logic             r_syn_start, r_kes_start, r_chien_start, r_cor_start;
  logic             r_out_valid;
  logic [TAG_W-1:0] r_out_tag;
  logic [1:0]       r_out_status;
  logic [2:0]       r_out_nerr;

  logic w_c_to_r, w_k_to_c, w_k_to_r, w_s_to_k, w_s_to_r;

  // Routing decisions use registered state only; a slot vacating this cycle
  // is not yet a legal destination. Into R, C wins over K wins over S.
  assign w_c_to_r = (r_c_st == DONE) && (r_r_st == IDLE);
  assign w_k_to_c = (r_k_st == DONE) && (r_k_status == ST_CLEAN) && (r_c_st == IDLE);
  assign w_k_to_r = (r_k_st == DONE) && (r_k_status != ST_CLEAN) && (r_c_st == IDLE) &&
                    (r_r_st == IDLE) && !w_c_to_r;
  assign w_s_to_k = (r_s_st == DONE) && !r_s_zero && (r_s_status == ST_CLEAN) &&
                    (r_k_st == IDLE);
  // A frame skipping K and C may only jump ahead when nothing is in between.
  assign w_s_to_r = (r_s_st == DONE) && (r_s_zero || (r_s_status == ST_TMO)) &&
                    (r_k_st == IDLE) && (r_c_st == IDLE) && (r_r_st == IDLE) &&
                    !w_c_to_r && !w_k_to_r;

  assign in_ready    = (r_s_st == IDLE);
  assign busy        = (r_s_st != IDLE) || (r_k_st != IDLE) || (r_c_st != IDLE) ||
                       (r_r_st != IDLE);
  assign syn_start   = r_syn_start;
  assign syn_tag     = r_s_tag;
  assign kes_start   = r_kes_start;
  assign kes_tag     = r_k_tag;
  assign chien_start = r_chien_start;
  assign chien_tag   = r_c_tag;
  assign cor_start   = r_cor_start;
  assign cor_tag     = r_r_tag;
  assign cor_bypass  = r_r_bypass;
  assign out_valid   = r_out_valid;
  assign out_tag     = r_out_tag;
  assign out_status  = r_out_status;
  assign out_nerr    = r_out_nerr;

  // S slot: accept a new frame, wait for the syndrome result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_st      <= IDLE;
      r_s_tag     <= '0;
      r_s_status  <= ST_CLEAN;
      r_s_zero    <= 1'b0;
      r_s_wd      <= '0;
      r_syn_start <= 1'b0;
    end else begin
      r_syn_start <= 1'b0;
      case (r_s_st)
        IDLE: if (in_valid) begin
          r_s_st      <= RUN;
          r_s_tag     <= in_tag;
          r_s_status  <= ST_CLEAN;
          r_s_zero    <= 1'b0;
          r_s_wd      <= '0;
          r_syn_start <= 1'b1;
        end
        RUN: if (syn_done) begin
          r_s_st   <= DONE;
          r_s_zero <= syn_zero;
        end else if (r_s_wd == WD_LAST) begin
          r_s_st     <= DONE;
          r_s_status <= ST_TMO;
        end else begin
          r_s_wd <= r_s_wd + WD_ONE;
        end
        DONE: if (w_s_to_k || w_s_to_r) r_s_st <= IDLE;
        default: r_s_st <= IDLE;
      endcase
    end
  end

  // K slot: run the key-equation solver and keep the locator degree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k_st      <= IDLE;
      r_k_tag     <= '0;
      r_k_status  <= ST_CLEAN;
      r_k_deg     <= '0;
      r_k_wd      <= '0;
      r_kes_start <= 1'b0;
    end else begin
      r_kes_start <= 1'b0;
      case (r_k_st)
        IDLE: if (w_s_to_k) begin
          r_k_st      <= RUN;
          r_k_tag     <= r_s_tag;
          r_k_status  <= ST_CLEAN;
          r_k_deg     <= '0;
          r_k_wd      <= '0;
          r_kes_start <= 1'b1;
        end
        RUN: if (kes_done) begin
          r_k_st <= DONE;
          if (kes_fail) r_k_status <= ST_UNCOR;
          else          r_k_deg    <= kes_deg;
        end else if (r_k_wd == WD_LAST) begin
          r_k_st     <= DONE;
          r_k_status <= ST_TMO;
        end else begin
          r_k_wd <= r_k_wd + WD_ONE;
        end
        DONE: if (w_k_to_c || w_k_to_r) r_k_st <= IDLE;
        default: r_k_st <= IDLE;
      endcase
    end
  end

  // C slot: Chien search; root count must match the locator degree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c_st        <= IDLE;
      r_c_tag       <= '0;
      r_c_status    <= ST_CLEAN;
      r_c_deg       <= '0;
      r_c_nerr      <= '0;
      r_c_wd        <= '0;
      r_chien_start <= 1'b0;
    end else begin
      r_chien_start <= 1'b0;
      case (r_c_st)
        IDLE: if (w_k_to_c) begin
          r_c_st        <= RUN;
          r_c_tag       <= r_k_tag;
          r_c_status    <= ST_CLEAN;
          r_c_deg       <= r_k_deg;
          r_c_nerr      <= '0;
          r_c_wd        <= '0;
          r_chien_start <= 1'b1;
        end
        RUN: if (chien_done) begin
          r_c_st <= DONE;
          if (chien_cnt == r_c_deg) begin
            r_c_status <= ST_CORR;
            r_c_nerr   <= chien_cnt;
          end else begin
            r_c_status <= ST_UNCOR;
            r_c_nerr   <= '0;
          end
        end else if (r_c_wd == WD_LAST) begin
          r_c_st     <= DONE;
          r_c_status <= ST_TMO;
          r_c_nerr   <= '0;
        end else begin
          r_c_wd <= r_c_wd + WD_ONE;
        end
        DONE: if (w_c_to_r) r_c_st <= IDLE;
        default: r_c_st <= IDLE;
      endcase
    end
  end

  // R slot: correction or bypass, then one status record per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r_st       <= IDLE;
      r_r_tag      <= '0;
      r_r_status   <= ST_CLEAN;
      r_r_nerr     <= '0;
      r_r_bypass   <= 1'b0;
      r_r_wd       <= '0;
      r_cor_start  <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_tag    <= '0;
      r_out_status <= ST_CLEAN;
      r_out_nerr   <= '0;
    end else begin
      r_cor_start <= 1'b0;
      r_out_valid <= 1'b0;
      case (r_r_st)
        IDLE: begin
          if (w_c_to_r) begin
            r_r_tag    <= r_c_tag;
            r_r_status <= r_c_status;
            r_r_nerr   <= r_c_nerr;
            r_r_bypass <= (r_c_status != ST_CORR);
          end else if (w_k_to_r) begin
            r_r_tag    <= r_k_tag;
            r_r_status <= r_k_status;
            r_r_nerr   <= '0;
            r_r_bypass <= 1'b1;
          end else if (w_s_to_r) begin
            r_r_tag    <= r_s_tag;
            r_r_status <= r_s_status;
            r_r_nerr   <= '0;
            r_r_bypass <= 1'b1;
          end
          if (w_c_to_r || w_k_to_r || w_s_to_r) begin
            r_r_st      <= RUN;
            r_r_wd      <= '0;
            r_cor_start <= 1'b1;
          end
        end
        RUN: if (cor_done) begin
          r_r_st       <= DONE;
          r_out_valid  <= 1'b1;
          r_out_tag    <= r_r_tag;
          r_out_status <= r_r_status;
          r_out_nerr   <= r_r_nerr;
        end else if (r_r_wd == WD_LAST) begin
          r_r_st       <= DONE;
          r_out_valid  <= 1'b1;
          r_out_tag    <= r_r_tag;
          r_out_status <= ST_TMO;
          r_out_nerr   <= '0;
        end else begin
          r_r_wd <= r_r_wd + WD_ONE;
        end
        DONE: r_r_st <= IDLE;
        default: r_r_st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_dec_sched_16_8.sv
// Bench for rs_dec_sched_16_8: stage responders answer start pulses with
// per-tag latencies and results; a monitor stamps starts and status records.
module tb_rs_dec_sched_16_8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid, in_ready;
  logic [1:0] in_tag;
  logic       syn_start, syn_done, syn_zero;
  logic [1:0] syn_tag;
  logic       kes_start, kes_done, kes_fail;
  logic [1:0] kes_tag;
  logic [2:0] kes_deg;
  logic       chien_start, chien_done;
  logic [1:0] chien_tag;
  logic [2:0] chien_cnt;
  logic       cor_start, cor_bypass, cor_done;
  logic [1:0] cor_tag;
  logic       out_valid;
  logic [1:0] out_tag;
  logic [1:0] out_status;
  logic [2:0] out_nerr;
  logic       busy;

  rs_dec_sched_16_8 #(.TAG_W(2), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .syn_start(syn_start), .syn_tag(syn_tag), .syn_done(syn_done), .syn_zero(syn_zero),
    .kes_start(kes_start), .kes_tag(kes_tag), .kes_done(kes_done), .kes_fail(kes_fail),
    .kes_deg(kes_deg),
    .chien_start(chien_start), .chien_tag(chien_tag), .chien_done(chien_done),
    .chien_cnt(chien_cnt),
    .cor_start(cor_start), .cor_bypass(cor_bypass), .cor_tag(cor_tag), .cor_done(cor_done),
    .out_valid(out_valid), .out_tag(out_tag), .out_status(out_status), .out_nerr(out_nerr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-tag responder behaviour (latency 0 = never answer).
  bit zero_a[4];
  bit fail_a[4];
  int deg_a[4], cnt_a[4];
  int lat_s[4], lat_k[4], lat_c[4], lat_r[4];

  initial begin : resp_syn
    int t;
    syn_done = 1'b0; syn_zero = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (syn_start && lat_s[syn_tag] != 0) begin
        t = int'(syn_tag);
        for (int j = 1; j < lat_s[t]; j++) begin @(posedge clk); #1; end
        syn_done = 1'b1; syn_zero = zero_a[t];
        @(posedge clk); #1;
        syn_done = 1'b0; syn_zero = 1'b0;
      end
    end
  end

  initial begin : resp_kes
    int t;
    kes_done = 1'b0; kes_fail = 1'b0; kes_deg = 3'd0;
    forever begin
      @(posedge clk); #1;
      if (kes_start && lat_k[kes_tag] != 0) begin
        t = int'(kes_tag);
        for (int j = 1; j < lat_k[t]; j++) begin @(posedge clk); #1; end
        kes_done = 1'b1; kes_fail = fail_a[t]; kes_deg = 3'(deg_a[t]);
        @(posedge clk); #1;
        kes_done = 1'b0; kes_fail = 1'b0; kes_deg = 3'd0;
      end
    end
  end

  initial begin : resp_chien
    int t;
    chien_done = 1'b0; chien_cnt = 3'd0;
    forever begin
      @(posedge clk); #1;
      if (chien_start && lat_c[chien_tag] != 0) begin
        t = int'(chien_tag);
        for (int j = 1; j < lat_c[t]; j++) begin @(posedge clk); #1; end
        chien_done = 1'b1; chien_cnt = 3'(cnt_a[t]);
        @(posedge clk); #1;
        chien_done = 1'b0; chien_cnt = 3'd0;
      end
    end
  end

  initial begin : resp_cor
    int t;
    cor_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (cor_start && lat_r[cor_tag] != 0) begin
        t = int'(cor_tag);
        for (int j = 1; j < lat_r[t]; j++) begin @(posedge clk); #1; end
        cor_done = 1'b1;
        @(posedge clk); #1;
        cor_done = 1'b0;
      end
    end
  end

  // Monitor: cycle stamps of starts and every status record.
  int syn_cyc[4], kes_n[4], ch_n[4], cor_cyc[4], cor_byp[4];
  int n_out = 0;
  int o_tag[64], o_st[64], o_nerr[64], o_cyc[64];

  always @(negedge clk) begin
    if (syn_start) syn_cyc[syn_tag] <= cyc;
    if (kes_start) kes_n[kes_tag] <= kes_n[kes_tag] + 1;
    if (chien_start) ch_n[chien_tag] <= ch_n[chien_tag] + 1;
    if (cor_start) begin
      cor_cyc[cor_tag] <= cyc;
      cor_byp[cor_tag] <= int'(cor_bypass);
    end
    if (out_valid && n_out < 64) begin
      o_tag[n_out]  <= int'(out_tag);
      o_st[n_out]   <= int'(out_status);
      o_nerr[n_out] <= int'(out_nerr);
      o_cyc[n_out]  <= cyc;
      n_out         <= n_out + 1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_quiet(input string pfx);
    chk({pfx, "_pulses"}, int'({syn_start, kes_start, chien_start, cor_start, cor_bypass,
                                out_valid}), 0);
    chk({pfx, "_tags"}, int'({syn_tag, kes_tag, chien_tag, cor_tag, out_tag}), 0);
    chk({pfx, "_outrec"}, int'({out_status, out_nerr}), 0);
    chk({pfx, "_busy"}, int'(busy), 0);
    chk({pfx, "_in_ready"}, int'(in_ready), 1);
  endtask

  task automatic send(input logic [1:0] tg);
    int k;
    k = 0;
    @(negedge clk);
    in_valid = 1'b1; in_tag = tg;
    while (!in_ready && k < 300) begin @(negedge clk); k++; end
    chk($sformatf("accept_tag%0d", tg), int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int target, input int budget, input string nm);
    int k;
    k = 0;
    while (n_out < target && k < budget) begin @(posedge clk); k++; end
    chk(nm, int'(n_out >= target), 1);
  endtask

  typedef struct {
    logic [1:0] tag;
    bit zero; bit fail; int deg; int cnt; int lk; int lc;
    int e_kes; int e_ch; int e_byp; int e_st; int e_nerr; int e_lat;
  } vec_t;

  vec_t vt[8];
  vec_t v;
  int   base, kb, cb, saved;

  initial begin
    in_valid = 1'b0; in_tag = 2'd0;
    for (int i = 0; i < 4; i++) begin
      lat_s[i] = 1; lat_k[i] = 1; lat_c[i] = 1; lat_r[i] = 1;
      zero_a[i] = 1'b0; fail_a[i] = 1'b0; deg_a[i] = 0; cnt_a[i] = 0;
    end
    // tag zero fail deg cnt lat_k lat_c | kes chien bypass status nerr out-latency
    vt[0] = '{2'd2, 1'b0, 1'b0, 3, 3, 1,  1, 1, 1, 0, 1, 3, 7};   // corrected
    vt[1] = '{2'd1, 1'b1, 1'b0, 0, 0, 1,  1, 0, 0, 1, 0, 0, 3};   // clean, skips K/C
    vt[2] = '{2'd3, 1'b0, 1'b1, 2, 0, 1,  1, 1, 0, 1, 2, 0, 5};   // KES failure
    vt[3] = '{2'd0, 1'b0, 1'b0, 2, 1, 1,  1, 1, 1, 1, 2, 0, 7};   // root count mismatch
    vt[4] = '{2'd1, 1'b0, 1'b0, 4, 4, 1,  1, 1, 1, 0, 1, 4, 7};   // t=4 corrected
    vt[5] = '{2'd2, 1'b0, 1'b0, 3, 3, 1,  0, 1, 1, 1, 3, 0, 70};  // Chien watchdog
    vt[6] = '{2'd2, 1'b0, 1'b0, 3, 3, 1, 64, 1, 1, 0, 1, 3, 70};  // done in last cycle
    vt[7] = '{2'd0, 1'b0, 1'b0, 2, 2, 0,  1, 1, 0, 1, 3, 0, 68};  // KES watchdog

    // Reset state, during and after reset.
    repeat (2) @(negedge clk);
    chk_quiet("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("rst_release");

    // Single frames on an empty pipe.
    for (int i = 0; i < 8; i++) begin
      v = vt[i];
      zero_a[v.tag] = v.zero; fail_a[v.tag] = v.fail;
      deg_a[v.tag] = v.deg; cnt_a[v.tag] = v.cnt;
      lat_k[v.tag] = v.lk; lat_c[v.tag] = v.lc;
      kb = kes_n[v.tag]; cb = ch_n[v.tag]; base = n_out;
      send(v.tag);
      wait_out(base + 1, 400, $sformatf("v%0d_out_seen", i));
      chk($sformatf("v%0d_tag", i), o_tag[base], int'(v.tag));
      chk($sformatf("v%0d_status", i), o_st[base], v.e_st);
      chk($sformatf("v%0d_nerr", i), o_nerr[base], v.e_nerr);
      chk($sformatf("v%0d_kes_starts", i), kes_n[v.tag] - kb, v.e_kes);
      chk($sformatf("v%0d_chien_starts", i), ch_n[v.tag] - cb, v.e_ch);
      chk($sformatf("v%0d_bypass", i), cor_byp[v.tag], v.e_byp);
      chk($sformatf("v%0d_latency", i), o_cyc[base] - syn_cyc[v.tag], v.e_lat);
      repeat (3) @(posedge clk);
      lat_k[v.tag] = 1; lat_c[v.tag] = 1;
    end

    // A (errors, slow Chien) then B (clean): B must wait behind A.
    zero_a[0] = 1'b0; fail_a[0] = 1'b0; deg_a[0] = 2; cnt_a[0] = 2; lat_c[0] = 6;
    zero_a[1] = 1'b1;
    kb = kes_n[1]; base = n_out;
    send(2'd0);
    send(2'd1);
    repeat (3) @(negedge clk);
    chk("b2b_in_ready_blocked", int'(in_ready), 0);
    chk("b2b_busy", int'(busy), 1);
    wait_out(base + 2, 200, "b2b_out_seen");
    chk("b2b_first_tag", o_tag[base], 0);
    chk("b2b_first_status", o_st[base], 1);
    chk("b2b_first_nerr", o_nerr[base], 2);
    chk("b2b_second_tag", o_tag[base + 1], 1);
    chk("b2b_second_status", o_st[base + 1], 0);
    chk("b2b_second_kes_starts", kes_n[1] - kb, 0);
    chk("b2b_cor_gap", cor_cyc[1] - cor_cyc[0], 3);
    chk("b2b_out_gap", o_cyc[base + 1] - o_cyc[base], 3);
    repeat (3) @(posedge clk);

    // Fill S/K/C/R with frames that stall, then reset mid-flight.
    for (int i = 0; i < 4; i++) begin
      zero_a[i] = 1'b0; fail_a[i] = 1'b0; deg_a[i] = 1; cnt_a[i] = 1;
      lat_s[i] = 1; lat_k[i] = 1; lat_c[i] = 1; lat_r[i] = 1;
    end
    lat_r[0] = 0; lat_c[1] = 0; lat_k[2] = 0; lat_s[3] = 0;
    cb = ch_n[1]; kb = kes_n[2];
    send(2'd0); send(2'd1); send(2'd2); send(2'd3);
    repeat (6) @(negedge clk);
    chk("fill_busy", int'(busy), 1);
    chk("fill_in_ready", int'(in_ready), 0);
    chk("fill_chien_tag1", ch_n[1] - cb, 1);
    chk("fill_kes_tag2", kes_n[2] - kb, 1);
    saved = n_out;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_quiet("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (150) @(posedge clk);
    chk("midrst_no_out", n_out, saved);
    @(negedge clk);
    chk("midrst_idle_busy", int'(busy), 0);
    chk("midrst_idle_ready", int'(in_ready), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
